// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operation request and result bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       mode;
    logic             carry_in;
    logic             decimal;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry_out;
    logic             overflow;
    logic             negative;
    logic             zero;
    logic [3:0]       flag_mask;

    modport master (
        output in_valid, alu_a, alu_b, mode, carry_in, decimal, out_ready,
        input  in_ready, out_valid, alu_out, carry_out, overflow, negative, zero, flag_mask
    );

    modport slave (
        input  in_valid, alu_a, alu_b, mode, carry_in, decimal, out_ready,
        output in_ready, out_valid, alu_out, carry_out, overflow, negative, zero, flag_mask
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered 6502-style ALU with BCD adjust stage and valid/ready handshakes
module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter int DECIMAL_EN = 1
) (
    input logic     clk,
    input logic     reset,
    alu_pipe_if.slave bus
);
    localparam bit DEC_OK = (DECIMAL_EN != 0) && (WIDTH % 4 == 0);
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, ADJUST, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
    logic [3:0]       mask_q, mask_d;
    logic [WIDTH-1:0] a_q, a_d, bp_q, bp_d;
    logic             cin_q, cin_d, sub_q, sub_d;

    logic [WIDTH-1:0] b_eff, bin_res, adj_res;
    logic [WIDTH:0]   sum, diff;
    logic             bin_c, bin_v, bin_n, bin_z, is_dec, adj_c, in_ready, load;
    logic [3:0]       bin_mask;

    always_comb begin
        b_eff    = (bus.mode == 4'd1) ? ~bus.alu_b : bus.alu_b;
        sum      = {1'b0, bus.alu_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.carry_in};
        diff     = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{WIDTH{1'b0}}, 1'b1};
        bin_res  = bus.alu_a;
        bin_c    = bus.carry_in;
        bin_v    = 1'b0;
        bin_mask = 4'b1100;
        case (bus.mode)
            4'd0, 4'd1: begin
                bin_res  = sum[MSB:0];
                bin_c    = sum[WIDTH];
                bin_v    = (bus.alu_a[MSB] == b_eff[MSB]) && (sum[MSB] != bus.alu_a[MSB]);
                bin_mask = 4'b1111;
            end
            4'd2: bin_res = bus.alu_a & bus.alu_b;
            4'd3: bin_res = bus.alu_a | bus.alu_b;
            4'd4: bin_res = bus.alu_a ^ bus.alu_b;
            4'd5: begin
                {bin_c, bin_res} = {bus.alu_a, 1'b0};
                bin_mask = 4'b1110;
            end
            4'd6: begin
                {bin_res, bin_c} = {1'b0, bus.alu_a};
                bin_mask = 4'b1110;
            end
            4'd7: begin
                {bin_c, bin_res} = {bus.alu_a, bus.carry_in};
                bin_mask = 4'b1110;
            end
            4'd8: begin
                {bin_res, bin_c} = {bus.carry_in, bus.alu_a};
                bin_mask = 4'b1110;
            end
            4'd9: begin
                bin_c    = diff[WIDTH];
                bin_mask = 4'b1110;
            end
            4'd10: bin_res = bus.alu_a + WIDTH'(1);
            4'd11: bin_res = bus.alu_a - WIDTH'(1);
            default: bin_res = bus.alu_a;
        endcase
        // CMP leaves A untouched but reports N/Z of the difference
        if (bus.mode == 4'd9) begin
            bin_n = diff[MSB];
            bin_z = (diff[MSB:0] == '0);
        end else begin
            bin_n = bin_res[MSB];
            bin_z = (bin_res == '0);
        end
        is_dec = DEC_OK && bus.decimal && (bus.mode == 4'd0 || bus.mode == 4'd1);
    end

    // Nibble-serial decimal correction, carry rippling from the least significant nibble
    always_comb begin
        logic [4:0] t;
        logic [3:0] nib;
        logic       cy;
        adj_res = '0;
        t       = '0;
        nib     = '0;
        cy      = cin_q;
        for (int i = 0; i < WIDTH / 4; i++) begin
            t = {1'b0, a_q[4*i +: 4]} + {1'b0, bp_q[4*i +: 4]} + {4'b0000, cy};
            if (sub_q) begin
                cy  = t[4];
                nib = cy ? t[3:0] : t[3:0] - 4'd6;
            end else begin
                cy  = (t > 5'd9);
                nib = cy ? t[3:0] + 4'd6 : t[3:0];
            end
            adj_res[4*i +: 4] = nib;
        end
        adj_c = cy;
    end

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
        load     = bus.in_valid && in_ready;
        state_d  = state_q;
        out_d    = out_q;
        c_d      = c_q;
        v_d      = v_q;
        n_d      = n_q;
        z_d      = z_q;
        mask_d   = mask_q;
        a_d      = a_q;
        bp_d     = bp_q;
        cin_d    = cin_q;
        sub_d    = sub_q;
        case (state_q)
            ADJUST: begin
                out_d   = adj_res;
                c_d     = adj_c;
                n_d     = adj_res[MSB];
                z_d     = (adj_res == '0);
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_d   = bin_res;
            c_d     = bin_c;
            v_d     = bin_v;
            n_d     = bin_n;
            z_d     = bin_z;
            mask_d  = bin_mask;
            a_d     = bus.alu_a;
            bp_d    = b_eff;
            cin_d   = bus.carry_in;
            sub_d   = (bus.mode == 4'd1);
            state_d = is_dec ? ADJUST : DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            mask_q  <= 4'b0000;
            a_q     <= '0;
            bp_q    <= '0;
            cin_q   <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            c_q     <= c_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            mask_q  <= mask_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            cin_q   <= cin_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.alu_out   = out_q;
    assign bus.carry_out = c_q;
    assign bus.overflow  = v_q;
    assign bus.negative  = n_q;
    assign bus.zero      = z_q;
    assign bus.flag_mask = mask_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed-vector bench for alu_pipe at WIDTH 8 and 16
module tb_alu_pipe;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    alu_pipe_if #(.WIDTH(8))  a8 ();
    alu_pipe_if #(.WIDTH(16)) a16 ();

    alu_pipe #(.WIDTH(8),  .DECIMAL_EN(1)) u8  (.clk(clk), .reset(reset), .bus(a8));
    alu_pipe #(.WIDTH(16), .DECIMAL_EN(1)) u16 (.clk(clk), .reset(reset), .bus(a16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags8();
        return {a8.negative, a8.zero, a8.carry_out, a8.overflow};
    endfunction

    function automatic logic [3:0] flags16();
        return {a16.negative, a16.zero, a16.carry_out, a16.overflow};
    endfunction

    task automatic op8(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic d);
        a8.mode = m; a8.alu_a = a; a8.alu_b = b; a8.carry_in = c; a8.decimal = d;
        a8.in_valid = 1'b1;
        @(posedge clk); #1;
        a8.in_valid = 1'b0;
    endtask

    task automatic op16(input logic [3:0] m, input logic [15:0] a, input logic c);
        a16.mode = m; a16.alu_a = a; a16.alu_b = 16'h0000; a16.carry_in = c; a16.decimal = 1'b0;
        a16.in_valid = 1'b1;
        @(posedge clk); #1;
        a16.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        a8.in_valid = 1'b0; a8.out_ready = 1'b1; a8.alu_a = '0; a8.alu_b = '0;
        a8.mode = '0; a8.carry_in = 1'b0; a8.decimal = 1'b0;
        a16.in_valid = 1'b0; a16.out_ready = 1'b1; a16.alu_a = '0; a16.alu_b = '0;
        a16.mode = '0; a16.carry_in = 1'b0; a16.decimal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", a8.out_valid, 1'b0);
        chk("rst_out",   a8.alu_out, 8'h00);
        chk("rst_flags", flags8(), 4'b0000);
        chk("rst_mask",  a8.flag_mask, 4'b0000);
        reset = 1'b0;
        step();
        chk("idle_ready", a8.in_ready, 1'b1);

        op8(4'd0, 8'h50, 8'h50, 1'b0, 1'b0);
        chk("adc_valid", a8.out_valid, 1'b1);
        chk("adc_out",   a8.alu_out, 8'hA0);
        chk("adc_flags", flags8(), 4'b1001);
        chk("adc_mask",  a8.flag_mask, 4'b1111);

        op8(4'd0, 8'h19, 8'h28, 1'b0, 1'b1);
        chk("dadc_wait",  a8.out_valid, 1'b0);
        chk("dadc_stall", a8.in_ready, 1'b0);
        step();
        chk("dadc_valid", a8.out_valid, 1'b1);
        chk("dadc_out",   a8.alu_out, 8'h47);
        chk("dadc_flags", flags8(), 4'b0000);

        op8(4'd0, 8'h99, 8'h01, 1'b0, 1'b1);
        step();
        chk("dadc99_out",   a8.alu_out, 8'h00);
        chk("dadc99_flags", flags8(), 4'b0110);

        op8(4'd1, 8'h42, 8'h13, 1'b1, 1'b1);
        step();
        chk("dsbc_out",   a8.alu_out, 8'h29);
        chk("dsbc_flags", flags8(), 4'b0010);

        op8(4'd1, 8'h00, 8'h01, 1'b1, 1'b0);
        chk("sbc_out",   a8.alu_out, 8'hFF);
        chk("sbc_flags", flags8(), 4'b1000);
        chk("sbc_mask",  a8.flag_mask, 4'b1111);

        op8(4'd9, 8'h40, 8'h40, 1'b0, 1'b0);
        chk("cmp_out",   a8.alu_out, 8'h40);
        chk("cmp_flags", flags8(), 4'b0110);
        chk("cmp_mask",  a8.flag_mask, 4'b1110);

        op8(4'd0, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("adcc_out",   a8.alu_out, 8'h00);
        chk("adcc_flags", flags8(), 4'b0110);

        op8(4'd10, 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("inc_out",   a8.alu_out, 8'h00);
        chk("inc_flags", flags8(), 4'b0100);
        chk("inc_mask",  a8.flag_mask, 4'b1100);

        op8(4'd11, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("dec_out",   a8.alu_out, 8'hFF);
        chk("dec_flags", flags8(), 4'b1010);

        op8(4'd6, 8'h01, 8'h00, 1'b0, 1'b0);
        chk("lsr_out",   a8.alu_out, 8'h00);
        chk("lsr_flags", flags8(), 4'b0110);

        op8(4'd7, 8'h80, 8'h00, 1'b1, 1'b0);
        chk("rol_out",   a8.alu_out, 8'h01);
        chk("rol_flags", flags8(), 4'b0010);

        op8(4'd2, 8'hFF, 8'h0F, 1'b0, 1'b1);
        chk("and_dec_valid", a8.out_valid, 1'b1);
        chk("and_dec_out",   a8.alu_out, 8'h0F);

        op8(4'd13, 8'h7E, 8'h11, 1'b0, 1'b0);
        chk("pass_out",  a8.alu_out, 8'h7E);
        chk("pass_mask", a8.flag_mask, 4'b1100);

        step();
        a8.out_ready = 1'b0;
        op8(4'd4, 8'hFF, 8'h0F, 1'b1, 1'b0);
        chk("eor_out",   a8.alu_out, 8'hF0);
        chk("eor_flags", flags8(), 4'b1010);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_valid", a8.out_valid, 1'b1);
            chk("hold_out",   a8.alu_out, 8'hF0);
            chk("hold_flags", flags8(), 4'b1010);
            chk("hold_ready", a8.in_ready, 1'b0);
        end
        a8.out_ready = 1'b1;
        #1;
        chk("release_ready", a8.in_ready, 1'b1);
        op8(4'd2, 8'hF0, 8'h3C, 1'b0, 1'b0);
        chk("and_valid", a8.out_valid, 1'b1);
        chk("and_out",   a8.alu_out, 8'h30);
        chk("and_flags", flags8(), 4'b0000);
        step();
        chk("drain_valid", a8.out_valid, 1'b0);

        op16(4'd8, 16'h0001, 1'b1);
        chk("ror16_out",   a16.alu_out, 16'h8000);
        chk("ror16_flags", flags16(), 4'b1010);
        op16(4'd5, 16'h8000, 1'b0);
        chk("asl16_out",   a16.alu_out, 16'h0000);
        chk("asl16_flags", flags16(), 4'b0110);
        chk("asl16_mask",  a16.flag_mask, 4'b1110);

        op8(4'd6, 8'h03, 8'h00, 1'b0, 1'b0);
        op8(4'd0, 8'h19, 8'h28, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", a8.out_valid, 1'b0);
        chk("midrst_out",   a8.alu_out, 8'h00);
        chk("midrst_flags", flags8(), 4'b0000);
        chk("midrst_mask",  a8.flag_mask, 4'b0000);
        step();
        reset = 1'b0;
        #1;
        chk("postrst_ready", a8.in_ready, 1'b1);
        step();
        chk("postrst_valid", a8.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
